sdram_port_scheduler: RTL and testbench

Dynamic SDRAM access scheduler that multiplexes one real-time read port (line buffer) and NPORT bulk read/write ports (background, score, note, PCM) onto the single SDRAM controller request bus (ar_*). It replaces fixed per-phase scheduling with priority plus round-robin arbitration at transaction boundaries, with a burst cap per bulk grant. It sits between the drawing/audio engines and the SDRAM controller, after SD-card/memory initialization has released the bus.

---
 rtl/sdram_port_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_port_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_scheduler.sv
// Arbitrates one real-time read port and NPORT bulk ports onto the single SDRAM request bus.
// Optional build macro SDRAM_SCHED_AGING_EN lets long-waiting bulk ports jump ahead of RT.
module sdram_port_scheduler #(
    parameter int unsigned NPORT     = 4,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned BE_W      = 16,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned AGE_LIMIT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      rt_rd,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic [DATA_W-1:0]         rt_rddata,
    output logic                      rt_ac,
    output logic                      rt_wait,
    input  logic [NPORT-1:0]          bk_rd,
    input  logic [NPORT-1:0]          bk_wr,
    input  logic [NPORT*ADDR_W-1:0]   bk_addr,
    input  logic [NPORT*DATA_W-1:0]   bk_wrdata,
    input  logic [NPORT*BE_W-1:0]     bk_be,
    output logic [DATA_W-1:0]         bk_rddata,
    output logic [NPORT-1:0]          bk_ac,
    output logic [NPORT-1:0]          bk_wait,
    output logic [ADDR_W-1:0]         ar_addr,
    output logic [BE_W-1:0]           ar_be,
    output logic                      ar_read,
    output logic                      ar_write,
    output logic [DATA_W-1:0]         ar_wrdata,
    input  logic                      ar_ac,
    input  logic [DATA_W-1:0]         ar_rddata,
    output logic [3:0]                grant_id
);

    localparam int unsigned IDX_W = $clog2(NPORT);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGrantRt = 2'd1;
    localparam logic [1:0] StGrantBk = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, rr_q, rr_d;
    logic [7:0]       burst_q, burst_d;
    logic             promo_q, promo_d;

    logic [NPORT-1:0] bk_req, owner_oh, arb_mask;
    logic [IDX_W-1:0] owner_inc, arb_start, arb_p, arb_idx, aged_idx, pick_owner;
    logic             arb_found, aged_found, own_req, pick_promo;
    logic [1:0]       pick_state;
    logic [7:0]       burst_inc;

    assign bk_req    = bk_rd | bk_wr;
    assign owner_oh  = {{(NPORT-1){1'b0}}, 1'b1} << owner_q;
    assign own_req   = bk_req[owner_q];
    assign owner_inc = (owner_q == IDX_W'(NPORT - 1)) ? '0 : owner_q + 1'b1;
    assign burst_inc = burst_q + 8'd1;

    // At a bulk boundary the owner's request counts as consumed and the search starts past it.
    always_comb begin
        arb_mask  = (state_q == StGrantBk) ? (bk_req & ~owner_oh) : bk_req;
        arb_start = (state_q == StGrantBk) ? owner_inc : rr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_p     = '0;
        for (int k = 0; k < NPORT; k++) begin
            arb_p = IDX_W'((int'(arb_start) + k) % int'(NPORT));
            if (!arb_found && arb_mask[arb_p]) begin
                arb_found = 1'b1;
                arb_idx   = arb_p;
            end
        end
    end

`ifdef SDRAM_SCHED_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q [NPORT];
    logic [AGE_W-1:0] age_d [NPORT];

    // Saturated counters are all equal, so lowest index breaks the tie.
    always_comb begin
        aged_found = 1'b0;
        aged_idx   = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!aged_found && arb_mask[i] && age_q[i] == AGE_W'(AGE_LIMIT)) begin
                aged_found = 1'b1;
                aged_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            age_d[i] = age_q[i];
            if ((state_d == StGrantBk && owner_d == IDX_W'(i)) || !bk_req[i]) begin
                age_d[i] = '0;
            end else if (!(state_q == StGrantBk && owner_q == IDX_W'(i)) &&
                         age_q[i] != AGE_W'(AGE_LIMIT)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            age_q[i] <= reset ? '0 : age_d[i];
        end
    end
`else
    assign aged_found = 1'b0;
    assign aged_idx   = '0;
`endif

    always_comb begin
        pick_state = StIdle;
        pick_owner = owner_q;
        pick_promo = 1'b0;
        if (enable) begin
            if (aged_found) begin
                pick_state = StGrantBk;
                pick_owner = aged_idx;
                pick_promo = 1'b1;
            end else if (rt_rd) begin
                pick_state = StGrantRt;
            end else if (arb_found) begin
                pick_state = StGrantBk;
                pick_owner = arb_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        promo_d = promo_q;
        case (state_q)
            StIdle: begin
                state_d = pick_state;
                owner_d = pick_owner;
                promo_d = pick_promo;
                burst_d = '0;
            end
            StGrantRt: begin
                if (ar_ac) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (aged_found) begin
                        state_d = StGrantBk;
                        owner_d = aged_idx;
                        promo_d = 1'b1;
                        burst_d = '0;
                    end
                end else if (!rt_rd) begin
                    state_d = StIdle;
                end
            end
            StGrantBk: begin
                if (ar_ac) begin
                    if (burst_inc >= 8'(MAX_BURST) || rt_rd || promo_q || !enable) begin
                        rr_d    = owner_inc;
                        burst_d = '0;
                        state_d = pick_state;
                        owner_d = pick_owner;
                        promo_d = pick_promo;
                    end else begin
                        burst_d = burst_inc;
                    end
                end else if (!own_req) begin
                    state_d = StIdle;
                    rr_d    = owner_inc;
                    burst_d = '0;
                    promo_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            promo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            promo_q <= promo_d;
        end
    end

    always_comb begin
        grant_id  = 4'd0;
        ar_addr   = '0;
        ar_be     = '1;
        ar_read   = 1'b0;
        ar_write  = 1'b0;
        ar_wrdata = '0;
        rt_wait   = 1'b1;
        rt_ac     = 1'b0;
        bk_wait   = '1;
        bk_ac     = '0;
        if (state_q == StGrantRt) begin
            grant_id = 4'd1;
            ar_addr  = rt_addr;
            ar_read  = rt_rd;
            rt_wait  = 1'b0;
            rt_ac    = ar_ac;
        end else if (state_q == StGrantBk) begin
            grant_id  = 4'(owner_q) + 4'd2;
            ar_addr   = bk_addr[int'(owner_q)*ADDR_W +: ADDR_W];
            ar_wrdata = bk_wrdata[int'(owner_q)*DATA_W +: DATA_W];
            ar_be     = bk_be[int'(owner_q)*BE_W +: BE_W];
            ar_write  = bk_wr[owner_q];
            ar_read   = bk_rd[owner_q] & ~bk_wr[owner_q];
            bk_wait   = ~owner_oh;
            bk_ac     = ar_ac ? owner_oh : '0;
        end
        rt_rddata = rt_ac ? ar_rddata : '0;
        bk_rddata = (|bk_ac) ? ar_rddata : '0;
    end

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler: reset, burst cap, RT preemption, rd+wr, reset, aging.
module tb_sdram_port_scheduler;

    localparam int NPORT  = 4;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 128;
    localparam int BE_W   = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enable = 1'b0;
    logic                    rt_rd = 1'b0;
    logic [ADDR_W-1:0]       rt_addr = '0;
    logic [DATA_W-1:0]       rt_rddata;
    logic                    rt_ac, rt_wait;
    logic [NPORT-1:0]        bk_rd = '0, bk_wr = '0;
    logic [NPORT*ADDR_W-1:0] bk_addr = '0;
    logic [NPORT*DATA_W-1:0] bk_wrdata = '0;
    logic [NPORT*BE_W-1:0]   bk_be = '1;
    logic [DATA_W-1:0]       bk_rddata;
    logic [NPORT-1:0]        bk_ac, bk_wait;
    logic [ADDR_W-1:0]       ar_addr;
    logic [BE_W-1:0]         ar_be;
    logic                    ar_read, ar_write;
    logic [DATA_W-1:0]       ar_wrdata;
    logic                    ar_ac = 1'b0;
    logic [DATA_W-1:0]       ar_rddata = '0;
    logic [3:0]              grant_id;

    int total = 0;
    int bad   = 0;

    sdram_port_scheduler #(
        .NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .MAX_BURST(8), .AGE_LIMIT(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rt_rd(rt_rd), .rt_addr(rt_addr), .rt_rddata(rt_rddata), .rt_ac(rt_ac),
        .rt_wait(rt_wait),
        .bk_rd(bk_rd), .bk_wr(bk_wr), .bk_addr(bk_addr), .bk_wrdata(bk_wrdata),
        .bk_be(bk_be), .bk_rddata(bk_rddata), .bk_ac(bk_ac), .bk_wait(bk_wait),
        .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
        .ar_wrdata(ar_wrdata), .ar_ac(ar_ac), .ar_rddata(ar_rddata), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int bk0_acks, rt_acks, first_bk0;

        repeat (2) step();
        reset = 1'b0;
        ar_ac = 1'b1;
        #1;
        check("rst_grant", grant_id, 0);
        check("rst_bk_wait", bk_wait, 4'hF);
        check("rst_rt_wait", rt_wait, 1);
        check("rst_ar_rw", {ar_read, ar_write}, 0);
        check("rst_ar_be", ar_be, 16'hFFFF);
        check("rst_ar_addr", ar_addr, 0);
        check("idle_ac_ignored", {rt_ac, bk_ac}, 0);
        check("idle_rddata", {rt_rddata, bk_rddata}, 0);

        // Burst cap: port 1 gets 8 acks, then port 2 the cycle after.
        step();
        ar_ac = 1'b0;
        enable = 1'b1;
        bk_wr = 4'b0110;
        bk_addr[1*ADDR_W +: ADDR_W] = 22'h111;
        bk_addr[2*ADDR_W +: ADDR_W] = 22'h222;
        #1;
        check("req_cycle_idle", grant_id, 0);
        step();
        #1;
        check("bk1_grant", grant_id, 3);
        check("bk1_addr", ar_addr, 22'h111);
        check("bk1_write", {ar_read, ar_write}, 2'b01);
        check("bk1_wait", bk_wait, 4'b1101);
        for (int n = 0; n < 8; n++) begin
            step();
            ar_ac = 1'b0;
            #1;
            check("bk1_hold", grant_id, 3);
            step();
            #1;
            check("bk1_hold", grant_id, 3);
            step();
            ar_ac = 1'b1;
            #1;
            check("bk1_ac", bk_ac, 4'b0010);
        end
        step();
        ar_ac = 1'b0;
        #1;
        check("bk2_grant", grant_id, 4);
        check("bk2_addr", ar_addr, 22'h222);
        check("bk2_wait", bk_wait, 4'b1011);
        step();
        ar_ac = 1'b1;
        #1;
        check("bk2_ac", bk_ac, 4'b0100);
        step();
        ar_ac = 1'b0;
        bk_wr = '0;
        step();
        #1;
        check("bk2_released", grant_id, 0);

        // RT preempts bulk port 0 at its next boundary.
        bk_rd = 4'b0001;
        bk_addr[0 +: ADDR_W] = 22'h0AA;
        step();
        #1;
        check("bk0_grant", grant_id, 2);
        check("bk0_read", {ar_read, ar_write}, 2'b10);
        check("bk0_addr", ar_addr, 22'h0AA);
        step();
        ar_ac = 1'b1;
        ar_rddata = 128'hD1D1;
        #1;
        check("bk0_ac", bk_ac, 4'b0001);
        check("bk0_rddata", bk_rddata, 128'hD1D1);
        check("bk0_rt_quiet", {rt_ac, rt_rddata}, 0);
        step();
        ar_ac = 1'b0;
        rt_rd = 1'b1;
        rt_addr = 22'h3C3;
        #1;
        check("bk0_keeps", grant_id, 2);
        check("rt_waiting", rt_wait, 1);
        step();
        ar_ac = 1'b1;
        ar_rddata = 128'hD2D2;
        #1;
        check("bk0_last_ac", {rt_ac, bk_ac}, 5'b00001);
        step();
        ar_ac = 1'b0;
        #1;
        check("rt_grant", grant_id, 1);
        check("rt_addr_out", ar_addr, 22'h3C3);
        check("rt_read", {ar_read, ar_write}, 2'b10);
        check("rt_be", ar_be, 16'hFFFF);
        check("rt_bk_wait", {rt_wait, bk_wait}, 5'b01111);
        step();
        ar_ac = 1'b1;
        ar_rddata = 128'hD3D3;
        #1;
        check("rt_ac", rt_ac, 1);
        check("rt_rddata", rt_rddata, 128'hD3D3);
        check("rt_bk_quiet", {bk_ac, bk_rddata}, 0);
        step();
        ar_ac = 1'b0;
        rt_rd = 1'b0;
        bk_rd = '0;
        #1;
        check("rt_kept", grant_id, 1);
        step();
        #1;
        check("rt_released", grant_id, 0);

        // rd and wr together act as a write; then reset mid-transaction.
        bk_rd = 4'b1000;
        bk_wr = 4'b1000;
        bk_be[3*BE_W +: BE_W] = 16'h000F;
        bk_wrdata[3*DATA_W +: DATA_W] = 128'hCAFE_F00D;
        step();
        reset = 1'b1;
        #1;
        check("bk3_grant", grant_id, 5);
        check("bk3_rw", {ar_read, ar_write}, 2'b01);
        check("bk3_be", ar_be, 16'h000F);
        check("bk3_wrdata", ar_wrdata, 128'hCAFE_F00D);
        step();
        reset = 1'b0;
        bk_rd = '0;
        bk_wr = '0;
        #1;
        check("rst_mid_write", ar_write, 0);
        check("rst_mid_grant", grant_id, 0);
        check("rst_mid_be", ar_be, 16'hFFFF);

        // RT held continuously with bulk port 0 waiting.
        bk0_acks = 0;
        rt_acks = 0;
        first_bk0 = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            rt_rd = 1'b1;
            bk_rd = 4'b0001;
            ar_ac = (i % 2) == 1;
            #1;
            if (bk_ac[0]) bk0_acks++;
            if (rt_ac) rt_acks++;
            if (grant_id == 4'd2 && first_bk0 < 0) first_bk0 = i;
        end
`ifdef SDRAM_SCHED_AGING_EN
        check("aged_bk0_acks", bk0_acks, 1);
        check("aged_rt_acks", rt_acks, 14);
        check("aged_first_cycle", first_bk0, 18);
`else
        check("starved_bk0_acks", bk0_acks, 0);
        check("rt_acks", rt_acks, 15);
        check("starved_no_grant", first_bk0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
